mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the single memory port (MAR/MDR/memEn/memOp/MFC).
//  Shares the port between requesting control FSMs: 0 = fetch, 1 = load, 2 = store.
//  Grants one requester at a time and drives memEn/memOp. Waits for MFC, returns a one-cycle
//  completion pulse to the granted requester, and flags a sticky error if MFC never arrives.
// PARAMETERS
//  NREQ     3   number of requesters (2..8)
//  TIMEOUT  16  max ACCESS cycles without MFC before abort; 0 disables the timeout
//  CNT_W    5   timeout counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk        in   1     system clock, rising edge
//  reset      in   1     synchronous, active-low reset
//  req        in   NREQ  per-requester memory request, level, held until done/err seen
//  op         in   NREQ  per-requester operation: 1 = read, 0 = write; sampled at grant
//  MFC        in   1     memory function complete from memory
//  gnt        out  NREQ  one-hot grant; granted FSM may drive MAR/MDR while set
//  memEn      out  1     memory enable to memory
//  memOp      out  1     memory operation to memory (latched op of granted requester)
//  done       out  NREQ  one-cycle completion pulse to granted requester
//  busy       out  1     1 whenever state != IDLE
//  timeout_err out 1     sticky; set on MFC timeout, cleared only by reset
// BEHAVIOUR
//  All outputs are registered. Reset (reset==0 at a clk edge) forces the following:
//   state=IDLE, gnt=0, memEn=0, memOp=0, done=0, busy=0, timeout_err=0, rr_ptr=0, cnt=0.
//  Reset mid-operation aborts the access immediately; no done pulse is issued.
//  States:
//   IDLE    - If any req bit is set, pick the first set index k searching from rr_ptr upward
//             with wrap. Set gnt[k]=1, latch op[k]; go to GRANT. Otherwise stay.
//   GRANT   - One cycle of address/data setup for the requester. Go to ACCESS with memEn=1,
//             memOp=latched op, cnt=0.
//   ACCESS  - If MFC=1: memEn=0, done[k]=1 for one cycle, go to RELEASE.
//             Else if TIMEOUT!=0 and cnt==TIMEOUT-1: memEn=0, timeout_err=1, no done, go to RELEASE.
//             Otherwise cnt+1 and stay.
//   RELEASE - done returns to 0. If req[k]==0: gnt=0, rr_ptr=(k+1) mod NREQ, go to IDLE.
//             Otherwise hold gnt and wait.
//  Latency from IDLE with req[k] sampled high at edge E0:
//   gnt at E0, memEn at E1. MFC sampled at En gives done high for the cycle after En.
//   Minimum E0 to done is 2 edges. IDLE always costs >=1 cycle between grants.
//  Boundary rules:
//   - Simultaneous requests: resolved strictly by rr_ptr order; other requests stay pending.
//   - req[k] dropped during GRANT/ACCESS: ignored; the memory access runs to MFC or timeout.
//   - MFC high in IDLE/GRANT/RELEASE: ignored; does not affect state or done.
//   - MFC and timeout on the same cycle: MFC wins; done is pulsed and timeout_err is unchanged.
//   - op changes after grant: ignored; memOp stays constant for the whole transaction.
//   - rr_ptr wraps from NREQ-1 to 0. Never more than one gnt bit set; gnt==0 in IDLE.
//   - cnt saturates, never wraps; it is cleared on entry to ACCESS.
// TESTING
//  T1 Single read: req=3'b010, op=3'b010, MFC after 3 ACCESS cycles ->
//     gnt=010 for 1 cycle before memEn=1, memOp=1, done=010 for exactly 1 cycle, gnt=0 after req drops.
//  T2 Contention: req=3'b111 held, rr_ptr=0, MFC 1 cycle after each memEn ->
//     grant order 001,010,100,001; memOp follows each requester's op.
//  T3 Timeout: TIMEOUT=16, req=3'b100, MFC never asserted ->
//     memEn high exactly 16 cycles, timeout_err=1 sticky, done stays 0, gnt released after req drops.
//  T4 Reset mid-ACCESS: reset=0 for 1 edge while memEn=1 ->
//     all outputs 0 next cycle; next grant starts from index 0.
//  T5 Abandoned request: req[0] dropped during ACCESS, MFC later ->
//     access completes, done[0] pulses, gnt cleared on the following cycle, IDLE.
//  T6 Spurious MFC in IDLE and RELEASE -> no done pulse, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Round-robin arbiter and sequencer for the single memory port. Control FSMs
//   (0 = fetch, 1 = load, 2 = store) request the port. One requester is granted
//   at a time. The block drives memEn/memOp, waits for MFC and then returns a
//   one-cycle done pulse to the granted requester. If MFC never arrives within
//   TIMEOUT access cycles, the access is aborted and a sticky timeout_err is set.
//
// Ports
//   clk          in   1     system clock, rising edge
//   reset        in   1     synchronous, active-low reset
//   req          in   NREQ  per-requester request, level, held until done/err
//   op           in   NREQ  per-requester operation (1 = read, 0 = write)
//   MFC          in   1     memory function complete
//   gnt          out  NREQ  one-hot grant
//   memEn        out  1     memory enable
//   memOp        out  1     memory operation (latched op of the granted requester)
//   done         out  NREQ  one-cycle completion pulse to the granted requester
//   busy         out  1     high whenever the sequencer is not idle
//   timeout_err  out  1     sticky MFC-timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    input  logic            MFC,
    output logic [NREQ-1:0] gnt,
    output logic            memEn,
    output logic            memOp,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic            timeout_err
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMO_LAST_INT = (TIMEOUT == 0) ? 0 : (TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_INT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_ACCESS  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Internal registers
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic             op_lat;
    logic [CNT_W-1:0] cnt;

    // Next values of every register
    logic [NREQ-1:0]  gnt_d;
    logic             mem_en_d;
    logic             mem_op_d;
    logic [NREQ-1:0]  done_d;
    logic             busy_d;
    logic             timeout_err_d;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] owner_d;
    logic             op_lat_d;
    logic [CNT_W-1:0] cnt_d;

    // Round-robin pick
    logic             pick_vld_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic [IDX_W-1:0] cand_c;
    logic             tmo_hit_c;

    // First requesting index found searching upward from rr_ptr with wrap
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        cand_c     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand_c = IDX_W'((32'(rr_ptr) + i) % NREQ);
            if (!pick_vld_c && req[cand_c]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = cand_c;
            end
        end
    end

    // Last permitted access cycle without MFC; never fires when TIMEOUT is 0
    assign tmo_hit_c = (TIMEOUT != 0) && (cnt == TMO_LAST);

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            gnt         <= '0;
            memEn       <= 1'b0;
            memOp       <= 1'b0;
            done        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rr_ptr      <= '0;
            owner       <= '0;
            op_lat      <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_d;
            memEn       <= mem_en_d;
            memOp       <= mem_op_d;
            done        <= done_d;
            busy        <= busy_d;
            timeout_err <= timeout_err_d;
            rr_ptr      <= rr_ptr_d;
            owner       <= owner_d;
            op_lat      <= op_lat_d;
            cnt         <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_vld_c) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (MFC || tmo_hit_c) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!req[owner]) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        gnt_d         = gnt;
        mem_en_d      = memEn;
        mem_op_d      = memOp;
        done_d        = '0;
        timeout_err_d = timeout_err;
        rr_ptr_d      = rr_ptr;
        owner_d       = owner;
        op_lat_d      = op_lat;
        cnt_d         = cnt;
        busy_d        = (state_nxt != S_IDLE);

        case (state)
            S_IDLE: begin
                if (pick_vld_c) begin
                    gnt_d    = NREQ'(1) << pick_idx_c;
                    owner_d  = pick_idx_c;
                    op_lat_d = op[pick_idx_c];
                end
            end
            S_GRANT: begin
                mem_en_d = 1'b1;
                mem_op_d = op_lat;
                cnt_d    = '0;
            end
            S_ACCESS: begin
                // MFC takes priority over a simultaneous timeout
                if (MFC) begin
                    mem_en_d = 1'b0;
                    done_d   = NREQ'(1) << owner;
                end else if (tmo_hit_c) begin
                    mem_en_d      = 1'b0;
                    timeout_err_d = 1'b1;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!req[owner]) begin
                    gnt_d    = '0;
                    rr_ptr_d = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                end
            end
            default: begin
                gnt_d    = '0;
                mem_en_d = 1'b0;
            end
        endcase
    end

endmodule
